tone_gen: RTL and testbench

Square-wave tone generator for the electric piano. It sits directly downstream of the octave selector, takes that 3-bit octave value and a 4-bit note index from the keyboard scanner, and drives the speaker pin. Pitch changes are glitch-free: a new pitch takes effect only at a half-period boundary.

---
 rtl/tone_gen_if.sv | 34 +++
 rtl/tone_gen.sv | 122 ++++++++++++
 tb/tb_tone_gen.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tone_gen_if.sv
// Keyboard/octave inputs and speaker outputs of the tone generator.
// With TONE_GEN_VOLUME_EN defined, a 4-bit volume input is added.
interface tone_gen_if;
  logic [2:0] octave;
  logic [3:0] key;
`ifdef TONE_GEN_VOLUME_EN
  logic [3:0] volume;
`endif
  logic       audio;
  logic       playing;
  logic       edge_strobe;

  modport master (
    output octave,
    output key,
`ifdef TONE_GEN_VOLUME_EN
    output volume,
`endif
    input  audio,
    input  playing,
    input  edge_strobe
  );

  modport slave (
    input  octave,
    input  key,
`ifdef TONE_GEN_VOLUME_EN
    input  volume,
`endif
    output audio,
    output playing,
    output edge_strobe
  );
endinterface

// File: rtl/tone_gen.sv
// Square-wave tone generator: note/octave to half-period, glitch-free pitch changes.
// Optional TONE_GEN_VOLUME_EN adds a 16-step PWM volume gate on the audio pin.
module tone_gen #(
  parameter int unsigned CLK_HZ = 100000000,
  parameter int unsigned CNT_W  = 22
) (
  input logic       clk,
  input logic       rst_n,
  tone_gen_if.slave bus
);

  typedef enum logic {IDLE, PLAY} state_e;
  typedef logic [CNT_W-1:0] hp_t;

  // Octave-0 half-period in clocks for note n (equal temperament, A4 = 440 Hz).
  function automatic hp_t note_hp(input int n);
    real f;
    f = 440.0 * (2.0 ** (real'(n - 57) / 12.0));
    return hp_t'($rtoi(real'(CLK_HZ) / (2.0 * f) + 0.5));
  endfunction

  localparam hp_t NOTE_TABLE [16] = '{
    note_hp(0), note_hp(1), note_hp(2),  note_hp(3),
    note_hp(4), note_hp(5), note_hp(6),  note_hp(7),
    note_hp(8), note_hp(9), note_hp(10), note_hp(11),
    hp_t'(0),   hp_t'(0),   hp_t'(0),    hp_t'(0)
  };

  logic [2:0] req_oct_q;
  logic [3:0] req_key_q;
  hp_t        hp_pend_q;
  logic       rest_pend_q;

  state_e     state_q, state_d;
  hp_t        count_q, count_d;
  hp_t        hp_act_q, hp_act_d;
  logic       square_q, square_d;
  logic       strobe_q, strobe_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_oct_q   <= 3'd0;
      req_key_q   <= 4'd15;
      hp_pend_q   <= '0;
      rest_pend_q <= 1'b1;
    end else begin
      req_oct_q   <= bus.octave;
      req_key_q   <= bus.key;
      hp_pend_q   <= NOTE_TABLE[req_key_q] >> req_oct_q;
      rest_pend_q <= (req_key_q >= 4'd12);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      count_q  <= '0;
      hp_act_q <= '0;
      square_q <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      hp_act_q <= hp_act_d;
      square_q <= square_d;
      strobe_q <= strobe_d;
    end
  end

  // Pending pitch/rest is only consulted at a half-period boundary, so halves never shorten.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    hp_act_d = hp_act_q;
    square_d = square_q;
    strobe_d = 1'b0;
    case (state_q)
      IDLE: begin
        square_d = 1'b0;
        count_d  = '0;
        if (!rest_pend_q) begin
          state_d  = PLAY;
          hp_act_d = hp_pend_q;
          square_d = 1'b1;
          strobe_d = 1'b1;
        end
      end
      PLAY: begin
        if (count_q == hp_act_q - hp_t'(1)) begin
          count_d = '0;
          if (rest_pend_q) begin
            state_d  = IDLE;
            square_d = 1'b0;
          end else begin
            square_d = ~square_q;
            strobe_d = ~square_q;
            hp_act_d = hp_pend_q;
          end
        end else begin
          count_d = count_q + hp_t'(1);
        end
      end
    endcase
  end

  assign bus.playing     = (state_q == PLAY);
  assign bus.edge_strobe = strobe_q;

`ifdef TONE_GEN_VOLUME_EN
  logic [3:0] pwm_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) pwm_cnt_q <= 4'd0;
    else        pwm_cnt_q <= pwm_cnt_q + 4'd1;
  end

  assign bus.audio = square_q & (pwm_cnt_q < bus.volume);
`else
  assign bus.audio = square_q;
`endif

endmodule

// File: tb/tb_tone_gen.sv
// Self-checking bench for tone_gen, run at a reduced CLK_HZ so whole notes fit in a short run.
// Half-periods are predicted from the tuning formula and compared with measured audio timing.
module tb_tone_gen;
  localparam int unsigned TB_CLK_HZ = 1000000;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  tone_gen_if tgif();

  tone_gen #(.CLK_HZ(TB_CLK_HZ)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (tgif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected half-period: rounded octave-0 half-period divided by 2^octave.
  function automatic int ref_hp(input int k, input int o);
    real f;
    int  base;
    f    = 440.0 * (2.0 ** (real'(k - 57) / 12.0));
    base = $rtoi(real'(TB_CLK_HZ) / (2.0 * f) + 0.5);
    return base / (2 ** o);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    tgif.key    = 4'd15;
    tgif.octave = 3'd0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    tgif.key    = 4'd9;
    tgif.octave = 3'd5;
    repeat (3) tick();
    checks++;
    if (tgif.audio !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_audio: got %b expected 0", tgif.audio);
    end
    checks++;
    if (tgif.playing !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_playing: got %b expected 0", tgif.playing);
    end
    checks++;
    if (tgif.edge_strobe !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_strobe: got %b expected 0", tgif.edge_strobe);
    end
    tgif.key = 4'd15;
    rst_n    = 1'b1;
    repeat (4) tick();
    checks++;
    if (tgif.playing !== 1'b0) begin
      errors++; $display("[TB] FAIL rest_idle_playing: got %b expected 0", tgif.playing);
    end
  endtask

`ifndef TONE_GEN_VOLUME_EN
  // Inputs are already applied; the next rising edge is the one that samples them.
  task automatic expect_start(input string name);
    for (int e = 0; e < 3; e++) begin
      tick();
      checks++;
      if (tgif.audio !== (e == 2)) begin
        errors++; $display("[TB] FAIL %s_latency_e%0d: audio got %b expected %b", name, e, tgif.audio, e == 2);
      end
    end
    checks++;
    if (tgif.playing !== 1'b1 || tgif.edge_strobe !== 1'b1) begin
      errors++; $display("[TB] FAIL %s_start: playing/strobe got %b%b expected 11", name, tgif.playing, tgif.edge_strobe);
    end
  endtask

  // first_cnt = cycles the current half has already been observed at its level.
  task automatic measure_halves(input int first_cnt, input int exp_first, input int exp_rest,
                                input int halves, input string name);
    logic lvl;
    int   cnt, stray, exp_len;
    for (int h = 0; h < halves; h++) begin
      lvl     = tgif.audio;
      cnt     = (h == 0) ? first_cnt : 1;
      exp_len = (h == 0) ? exp_first : exp_rest;
      stray   = 0;
      while (cnt < 4 * exp_len + 20) begin
        tick();
        if (tgif.audio !== lvl) break;
        cnt++;
        if (tgif.edge_strobe !== 1'b0) stray++;
      end
      checks++;
      if (cnt !== exp_len) begin
        errors++; $display("[TB] FAIL %s_half%0d_len: got %0d cycles expected %0d", name, h, cnt, exp_len);
      end
      checks++;
      if (stray !== 0) begin
        errors++; $display("[TB] FAIL %s_half%0d_stray_strobe: got %0d expected 0", name, h, stray);
      end
      checks++;
      if (tgif.edge_strobe !== (lvl ? 1'b0 : 1'b1)) begin
        errors++; $display("[TB] FAIL %s_half%0d_edge_strobe: got %b expected %b", name, h, tgif.edge_strobe, !lvl);
      end
    end
  endtask

  task automatic test_random_notes();
    int k, o;
    for (int n = 0; n < 4; n++) begin
      k = $urandom_range(0, 11);
      o = $urandom_range(5, 7);
      do_reset();
      tgif.key    = 4'(k);
      tgif.octave = 3'(o);
      $display("[TB] note key=%0d octave=%0d hp=%0d", k, o, ref_hp(k, o));
      expect_start("note");
      measure_halves(1, ref_hp(k, o), ref_hp(k, o), 4, "note");
    end
  endtask

  task automatic test_octave_change();
    do_reset();
    tgif.key    = 4'd9;
    tgif.octave = 3'd5;
    expect_start("octchg");
    repeat (100) tick();
    tgif.octave = 3'd6;
    measure_halves(101, ref_hp(9, 5), ref_hp(9, 6), 3, "octchg");
  endtask

  task automatic test_back_to_back();
    do_reset();
    tgif.key    = 4'd9;
    tgif.octave = 3'd5;
    expect_start("b2b");
    repeat (50) tick();
    tgif.key = 4'd15;
    repeat (5) tick();
    tgif.key    = 4'd0;
    tgif.octave = 3'd6;
    measure_halves(56, ref_hp(9, 5), ref_hp(0, 6), 3, "b2b");
  endtask

  task automatic test_rest(input bit in_high);
    int hp, cnt, runt, quiet;
    logic lvl;
    hp = ref_hp(4, 6);
    do_reset();
    tgif.key    = 4'd4;
    tgif.octave = 3'd6;
    expect_start("rest");
    if (!in_high) begin
      cnt = 0;
      while (tgif.audio !== 1'b0 && cnt < 4 * hp) begin
        tick();
        cnt++;
      end
    end
    lvl  = tgif.audio;
    cnt  = 1;
    runt = 0;
    repeat (10) begin
      tick();
      cnt++;
    end
    tgif.key = 4'd15;
    while (cnt < 4 * hp) begin
      tick();
      if (tgif.playing !== 1'b1) break;
      if (tgif.audio !== lvl) runt++;
      cnt++;
    end
    checks++;
    if (cnt !== hp) begin
      errors++; $display("[TB] FAIL rest_stop_time(high=%0d): got %0d expected %0d", in_high, cnt, hp);
    end
    checks++;
    if (runt !== 0) begin
      errors++; $display("[TB] FAIL rest_runt(high=%0d): got %0d expected 0", in_high, runt);
    end
    quiet = 0;
    repeat (2 * hp) begin
      tick();
      if (tgif.audio !== 1'b0 || tgif.playing !== 1'b0) quiet++;
    end
    checks++;
    if (quiet !== 0 || tgif.audio !== 1'b0) begin
      errors++; $display("[TB] FAIL rest_silent(high=%0d): got %0d active cycles expected 0", in_high, quiet);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    tgif.key    = 4'd9;
    tgif.octave = 3'd5;
    expect_start("rstmid");
    repeat (50) tick();
    rst_n = 1'b0;
    tick();
    checks++;
    if ({tgif.audio, tgif.playing, tgif.edge_strobe} !== 3'b000) begin
      errors++; $display("[TB] FAIL rstmid_outputs: got %b%b%b expected 000", tgif.audio, tgif.playing, tgif.edge_strobe);
    end
    rst_n = 1'b1;
    expect_start("rstmid_restart");
    measure_halves(1, ref_hp(9, 5), ref_hp(9, 5), 2, "rstmid");
  endtask
`else
  task automatic test_volume();
    int hp, t, ones;
    hp = ref_hp(9, 5);
    do_reset();
    tgif.volume = 4'd4;
    tgif.key    = 4'd9;
    tgif.octave = 3'd5;
    repeat (3) tick();
    checks++;
    if (tgif.playing !== 1'b1 || tgif.edge_strobe !== 1'b1) begin
      errors++; $display("[TB] FAIL vol_start: playing/strobe got %b%b expected 11", tgif.playing, tgif.edge_strobe);
    end
    for (int v = 0; v < 2; v++) begin
      t    = 0;
      ones = 0;
      while (t < 4 * hp) begin
        tick();
        t++;
        if (tgif.edge_strobe === 1'b1) break;
        if (tgif.playing !== 1'b1) ones += 1000;
        if (v == 0 && t >= 5 && t < 165 && tgif.audio === 1'b1) ones++;
        if (v == 1 && tgif.audio !== 1'b0) ones++;
        if (v == 0 && t == 200) tgif.volume = 4'd0;
      end
      checks++;
      if (t !== 2 * hp) begin
        errors++; $display("[TB] FAIL vol%0d_strobe_period: got %0d expected %0d", v, t, 2 * hp);
      end
      checks++;
      if (ones !== (v == 0 ? 40 : 0)) begin
        errors++; $display("[TB] FAIL vol%0d_duty: got %0d expected %0d", v, ones, v == 0 ? 40 : 0);
      end
    end
  endtask
`endif

  initial begin
    checks      = 0;
    errors      = 0;
    rst_n       = 1'b0;
    tgif.key    = 4'd15;
    tgif.octave = 3'd0;
`ifdef TONE_GEN_VOLUME_EN
    tgif.volume = 4'd15;
`endif
    test_reset();
`ifndef TONE_GEN_VOLUME_EN
    test_random_notes();
    test_octave_change();
    test_back_to_back();
    test_rest(1'b1);
    test_rest(1'b0);
    test_reset_mid();
`else
    test_volume();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
